// File: rtl/hex_entry_input_pkg.sv
// Shared definitions for the hex word entry block: FSM states and word geometry.
package hex_entry_input_pkg;

    typedef enum logic {
        ENTRY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int unsigned NIBBLES  = 4;
    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned WORD_W   = 16;

    // Shift one nibble into the low end of the word, dropping the oldest nibble.
    function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] word,
                                                   input logic [NIBBLE_W-1:0] nib);
        return {word[WORD_W-NIBBLE_W-1:0], nib};
    endfunction

endpackage

// File: rtl/hex_entry_input_button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, debounced
// level and a one-cycle pulse on each accepted press (release gives no pulse).
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic             meta;
    logic             sync;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Two-stage synchroniser; resets to the released (high) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
        end else begin
            meta <= key_n;
            sync <= meta;
        end
    end

    // Count consecutive samples that disagree with the debounced level. With a
    // 1-bit level any change either returns to the debounced level (clears) or
    // starts from a cleared count, so the equality test alone covers both cases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync;
                cnt   <= '0;
                press <= ~sync;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hex_entry_input.sv
// Hex word entry from switches and buttons: each enter press shifts the
// synchronised switch nibble in; four nibbles form a word offered with valid/ack.
module hex_entry_input
    import hex_entry_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                key_enter_n,
    input  logic                key_clear_n,
    input  logic [NIBBLE_W-1:0] sw,
    input  logic                data_ack,
    output logic [WORD_W-1:0]   DataOut,
    output logic                data_valid,
    output logic [2:0]          digit_cnt
);

    logic [NIBBLE_W-1:0] sw_meta;
    logic [NIBBLE_W-1:0] sw_sync;
    logic                enter_press;
    logic                clear_press;

    state_t              state;
    state_t              state_next;
    logic [WORD_W-1:0]   data_next;
    logic [2:0]          cnt_next;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_enter (
        .clk  (Clk),
        .rst  (Rst),
        .key_n(key_enter_n),
        .press(enter_press)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_clear (
        .clk  (Clk),
        .rst  (Rst),
        .key_n(key_clear_n),
        .press(clear_press)
    );

    // Two-stage synchroniser for the switch nibble.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sw_meta <= '1;
            sw_sync <= '1;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    // Entry FSM state, word and digit counter registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= ENTRY;
            DataOut   <= '0;
            digit_cnt <= '0;
        end else begin
            state     <= state_next;
            DataOut   <= data_next;
            digit_cnt <= cnt_next;
        end
    end

    // Next-state logic: clear has priority over everything; in FULL the word is
    // frozen and enter presses are dropped until the CPU acknowledges.
    always_comb begin
        state_next = state;
        data_next  = DataOut;
        cnt_next   = digit_cnt;
        if (clear_press) begin
            state_next = ENTRY;
            data_next  = '0;
            cnt_next   = '0;
        end else begin
            case (state)
                ENTRY: begin
                    if (enter_press) begin
                        data_next = shift_in(DataOut, sw_sync);
                        cnt_next  = digit_cnt + 3'd1;
                        if (digit_cnt == 3'(NIBBLES - 1)) begin
                            state_next = FULL;
                        end
                    end
                end
                FULL: begin
                    if (data_ack) begin
                        state_next = ENTRY;
                        cnt_next   = '0;
                    end
                end
                default: state_next = ENTRY;
            endcase
        end
    end

    assign data_valid = (state == FULL);

endmodule
